// File: rtl/strip_trig_pkg.sv
// Shared widths and the packed trigger word used between the band-id stage,
// the trigger info scheduler and the strip trigger serializer.
package strip_trig_pkg;

  localparam int BCID_W = 12;
  localparam int BAND_W = 8;
  localparam int PHI_W  = 5;
  localparam int TRIG_W = BCID_W + BAND_W + PHI_W;

  typedef struct packed {
    logic [BCID_W-1:0] bcid;
    logic [BAND_W-1:0] band_id;
    logic [PHI_W-1:0]  phi_id;
  } trig_word_t;

  function automatic trig_word_t pack_trig(input logic [BCID_W-1:0] bcid,
                                           input logic [BAND_W-1:0] band_id,
                                           input logic [PHI_W-1:0]  phi_id);
    trig_word_t w;
    w.bcid    = bcid;
    w.band_id = band_id;
    w.phi_id  = phi_id;
    return w;
  endfunction

endpackage

// File: rtl/trig_info_fifo.sv
// Small synchronous FIFO for trigger words. The head entry is always visible
// on 'head' (show-ahead), so a pop and the capture of the popped word happen
// on the same clock edge in the scheduler.
module trig_info_fifo
  import strip_trig_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  trig_word_t       din,
  output trig_word_t       head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  trig_word_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still legal when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/strip_trigger_info_scheduler.sv
// Buffers trigger words from the band-id stage and hands them to the strip
// trigger serializer one at a time, only on the chosen 160 MHz slot phase and
// only while the serializer is idle. Duplicates and overflows are counted.
module strip_trigger_info_scheduler
  import strip_trig_pkg::*;
#(
  parameter int  DEPTH       = 8,
  parameter int  SLOT_PHASE  = 3,
  parameter int  ACK_TIMEOUT = 16,
  parameter int  CNT_W       = 16,
  localparam int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_ready,
  input  logic [BCID_W-1:0] bcid_in,
  input  logic [BAND_W-1:0] band_id_in,
  input  logic [PHI_W-1:0]  phi_id_in,
  input  logic              gen_ready,
  output logic              load,
  output logic [BCID_W-1:0] bcid_out,
  output logic [BAND_W-1:0] band_id_out,
  output logic [PHI_W-1:0]  phi_id_out,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [CNT_W-1:0]  overflow_cnt,
  output logic [CNT_W-1:0]  dup_cnt,
  output logic [CNT_W-1:0]  timeout_cnt
);

  localparam int         TMR_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [1:0] SLOT_SEL = 2'(SLOT_PHASE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       slot_cnt;
  logic             slot_hit;
  logic [TMR_W-1:0] timer;
  trig_word_t       in_word;
  trig_word_t       head_word;
  trig_word_t       out_word;
  trig_word_t       last_word;
  logic             last_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop_req;
  logic             timeout_evt;
  logic             is_dup;
  logic             push_acc;
  logic             dup_evt;
  logic             ovf_evt;

  assign in_word  = pack_trig(bcid_in, band_id_in, phi_id_in);
  assign slot_hit = (slot_cnt == SLOT_SEL);

  // Dedup only against the most recent accepted word, and only while it is still meaningful.
  assign is_dup   = last_valid && (in_word == last_word);
  assign push_acc = data_ready && !is_dup && (!fifo_full || pop_req);
  assign dup_evt  = data_ready && is_dup;
  assign ovf_evt  = data_ready && !is_dup && fifo_full && !pop_req;

  trig_info_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_acc),
    .pop   (pop_req),
    .din   (in_word),
    .head  (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Free-running slot phase counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_cnt <= '0;
    else       slot_cnt <= slot_cnt + 1'b1;
  end

  // Issue FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Issue FSM next state: pop on a slot hit, then wait for the serializer to go busy and idle again.
  always_comb begin
    state_nxt   = state;
    pop_req     = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      IDLE: begin
        if (slot_hit && !fifo_empty && gen_ready) begin
          pop_req   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!gen_ready) begin
          state_nxt = WAIT_DONE;
        end else if (timer == TMR_LAST) begin
          timeout_evt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (gen_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load = (state == ISSUE);

  // Busy-response timer runs only while waiting for the serializer to react.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   timer <= '0;
    else if (state == WAIT_BUSY) timer <= timer + 1'b1;
    else                         timer <= '0;
  end

  // Output word register, updated only on a pop so it is stable through the load cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        out_word <= '0;
    else if (pop_req) out_word <= head_word;
  end

  assign bcid_out    = out_word.bcid;
  assign band_id_out = out_word.band_id;
  assign phi_id_out  = out_word.phi_id;

  // Last accepted word; forgotten once the FIFO drains so a later repeat is re-accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_word  <= '0;
      last_valid <= 1'b0;
    end else if (push_acc) begin
      last_word  <= in_word;
      last_valid <= 1'b1;
    end else if (pop_req && fifo_level == LVL_W'(1)) begin
      last_valid <= 1'b0;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_cnt <= '0;
      dup_cnt      <= '0;
      timeout_cnt  <= '0;
    end else begin
      if (ovf_evt && overflow_cnt != {CNT_W{1'b1}}) overflow_cnt <= overflow_cnt + 1'b1;
      if (dup_evt && dup_cnt != {CNT_W{1'b1}})      dup_cnt      <= dup_cnt + 1'b1;
      if (timeout_evt && timeout_cnt != {CNT_W{1'b1}}) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

endmodule
